cla_carry_pipe: RTL and testbench

- Pipelined carry-lookahead front end for the adder datapath.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Computes bit propagate/generate, 4-bit group lookahead and every bit carry, then registers the per-bit propagate vector and the per-bit carry-in vector.
- Sits directly upstream of the per-bit sum-generation array, which forms Sum[i] = c[i] XOR P[i] from this block's outputs.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_group4.sv | 23 ++
 rtl/cla_carry_pipe.sv | 145 ++++++++++++++
 tb/tb_cla_carry_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, group-count helper and S1 payload type for cla_carry_pipe
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_num_groups(input int width);
    return width / CLA_GROUP;
  endfunction

  // One lookahead group's share of the S1 payload.
  typedef struct packed {
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;
    logic                 pg;
    logic                 gg;
  } cla_s1_grp_t;

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit carry-lookahead group: bit carries, group P and G
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] i_p,
  input  logic [CLA_GROUP-1:0] i_g,
  input  logic                 i_c,
  output logic [CLA_GROUP-1:0] o_c,
  output logic                 o_pg,
  output logic                 o_gg
);

  assign o_c[0] = i_c;
  assign o_c[1] = i_g[0] | (i_p[0] & i_c);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c);

  assign o_pg = &i_p;
  assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
              | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

endmodule

// File: rtl/cla_carry_pipe.sv
// rtl/cla_carry_pipe.sv - two-stage carry-lookahead front end; CLA_OVF_EN adds signed overflow output ovf_o
module cla_carry_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] c_o,
  output logic             cout_o
`ifdef CLA_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int NG = cla_num_groups(WIDTH);

  logic [WIDTH-1:0]       w_p;
  logic [WIDTH-1:0]       w_g;
  logic [WIDTH-1:0]       w_s1_c;
  logic [NG-1:0]          w_pg;
  logic [NG-1:0]          w_gg;
  cla_s1_grp_t [NG-1:0]   w_s1_grp;

  cla_s1_grp_t [NG-1:0]   r_s1_grp;
  logic                   r_s1_cin;
  logic                   r_s1_valid;

  logic [NG:0]            w_gc;
  logic [WIDTH-1:0]       w_s2_p;
  logic [WIDTH-1:0]       w_c;
  logic [NG-1:0]          w_s2_pg;
  logic [NG-1:0]          w_s2_gg;

  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_p;
  logic [WIDTH-1:0]       r_c;
  logic                   r_cout;

  logic                   w_s1_en;
  logic                   w_s2_en;
  logic                   w_unused;

  assign w_p = a_i ^ b_i;
  assign w_g = a_i & b_i;

  // The same group cell serves both stages: S1 keeps only PG/GG, S2 only the bit carries.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_s1 (
      .i_p  (w_p[k*CLA_GROUP +: CLA_GROUP]),
      .i_g  (w_g[k*CLA_GROUP +: CLA_GROUP]),
      .i_c  (1'b0),
      .o_c  (w_s1_c[k*CLA_GROUP +: CLA_GROUP]),
      .o_pg (w_pg[k]),
      .o_gg (w_gg[k])
    );

    assign w_s1_grp[k].p  = w_p[k*CLA_GROUP +: CLA_GROUP];
    assign w_s1_grp[k].g  = w_g[k*CLA_GROUP +: CLA_GROUP];
    assign w_s1_grp[k].pg = w_pg[k];
    assign w_s1_grp[k].gg = w_gg[k];

    assign w_s2_p[k*CLA_GROUP +: CLA_GROUP] = r_s1_grp[k].p;

    cla_group4 u_s2 (
      .i_p  (r_s1_grp[k].p),
      .i_g  (r_s1_grp[k].g),
      .i_c  (w_gc[k]),
      .o_c  (w_c[k*CLA_GROUP +: CLA_GROUP]),
      .o_pg (w_s2_pg[k]),
      .o_gg (w_s2_gg[k])
    );
  end

  always_comb begin
    w_gc    = '0;
    w_gc[0] = r_s1_cin;
    for (int k = 0; k < NG; k++) begin
      w_gc[k+1] = r_s1_grp[k].gg | (r_s1_grp[k].pg & w_gc[k]);
    end
  end

  assign w_unused = ^{w_s1_c, w_s2_pg, w_s2_gg};

  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_grp    <= '0;
      r_s1_cin    <= 1'b0;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_c         <= '0;
      r_cout      <= 1'b0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_grp <= w_s1_grp;
          r_s1_cin <= cin_i;
        end
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_p    <= w_s2_p;
          r_c    <= w_c;
          r_cout <= w_gc[NG];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign p_o       = r_p;
  assign c_o       = r_c;
  assign cout_o    = r_cout;

`ifdef CLA_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_s2_en && r_s1_valid) begin
      r_ovf <= w_c[WIDTH-1] ^ w_gc[NG];
    end
  end

  assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_cla_carry_pipe.sv
// tb/tb_cla_carry_pipe.sv - randomized scoreboard bench for cla_carry_pipe
module tb_cla_carry_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p_o;
  logic [W-1:0] c_o;
  logic         cout_o;
`ifdef CLA_OVF_EN
  logic         ovf_o;
`endif

  cla_carry_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .cin_i     (cin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_o       (p_o),
    .c_o       (c_o),
    .cout_o    (cout_o)
`ifdef CLA_OVF_EN
    ,
    .ovf_o     (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic         cout;
    logic         ovf;
    logic [W:0]   sum;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_pop    = 0;
  bit   rnd_rdy  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference: carries recovered from the true integer sum, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    e.sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.p    = a ^ b;
    e.c    = e.sum[W-1:0] ^ e.p;
    e.cout = e.sum[W];
    e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic acc;
    in_valid = 1'b1;
    a_i      = a;
    b_i      = b;
    cin_i    = cin;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sb.push_back(model(a, b, cin));
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout in_ready never rose got=0 exp=1");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  logic         hold_v = 1'b0;
  logic [W-1:0] hold_p;
  logic [W-1:0] hold_c;
  logic         hold_cout;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_p", p_o, hold_p);
        chk("hold_c", c_o, hold_c);
        chk("hold_cout", cout_o, hold_cout);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_pop++;
          chk("p_o", p_o, e.p);
          chk("c_o", c_o, e.c);
          chk("cout_o", cout_o, e.cout);
          chk("sum", {cout_o, p_o ^ c_o}, e.sum);
`ifdef CLA_OVF_EN
          chk("ovf_o", ovf_o, e.ovf);
`endif
        end
      end
      hold_v    = out_valid && !out_ready;
      hold_p    = p_o;
      hold_c    = c_o;
      hold_cout = cout_o;
    end
  end

  initial begin
    int base;
    int t;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a_i       = W'($urandom);
    b_i       = W'($urandom);
    cin_i     = 1'b1;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_p_o", p_o, '0);
    chk("rst_c_o", c_o, '0);
    chk("rst_cout_o", cout_o, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    send(W'($urandom), W'($urandom), 1'b0);
    in_valid = 1'b0;
    chk("lat_after_accept", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_next_edge", out_valid, 1'b1);

    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h1234, 16'h4321, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h0000, 16'h0000, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    out_ready = 1'b0;
    base      = n_pop;
    send(W'($urandom), W'($urandom), 1'($urandom));
    send(W'($urandom), W'($urandom), 1'($urandom));
    chk("bp_full_in_ready", in_ready, 1'b0);
    fork
      send(W'($urandom), W'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_result_count", n_pop - base, 3);

    out_ready = 1'b0;
    send(W'($urandom), W'($urandom), 1'($urandom));
    send(W'($urandom), W'($urandom), 1'($urandom));
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        send(W'($urandom), W'($urandom), 1'($urandom));
      end
    end
    in_valid = 1'b0;
    rnd_rdy  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
